// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// for a shared-memory datapath, with memory wait-state timeout and sticky fault.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit FULL_BRANCH = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic        i_zero,
  input  logic        i_lt,
  input  logic        i_ltu,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_ir_write,
  output logic        o_reg_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_adr_src,
  output logic [1:0]  o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_result_src,
  output logic [2:0]  o_imm_src,
  output logic [3:0]  o_alu_ctrl,
  output logic        o_fault
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLT    = 4'b0101;
  localparam logic [3:0] ALU_SLTU   = 4'b0110;
  localparam logic [3:0] ALU_SLL    = 4'b0111;
  localparam logic [3:0] ALU_SRL    = 4'b1000;
  localparam logic [3:0] ALU_SRA    = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  // Counter only ever holds 0..MEM_TIMEOUT-1; the final wait cycle goes straight to FAULT.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JLINK    = 4'd13,
    S_FAULT    = 4'd14
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_wait_cnt;
  logic [CW-1:0]   w_wait_cnt_next;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_funct7_5;
  logic            w_wait_state;
  logic            w_timeout;
  logic            w_unused_instr;

  assign w_opcode       = i_instr[6:0];
  assign w_funct3       = i_instr[14:12];
  assign w_funct7_5     = i_instr[30];
  assign w_wait_state   = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_timeout      = (MEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST);
  assign w_unused_instr = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic branch_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001:                 ok = 1'b1;
      3'b100, 3'b101, 3'b110, 3'b111: ok = FULL_BRANCH;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    logic tk;
    case (f3)
      3'b000:  tk = z;
      3'b001:  tk = ~z;
      3'b100:  tk = lt;
      3'b101:  tk = ~lt;
      3'b110:  tk = ltu;
      3'b111:  tk = ~ltu;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  // State and wait-counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Wait counter: counts stalled cycles, clears on ready or when leaving a wait state
  always_comb begin
    if (w_wait_state && !i_mem_ready && !w_timeout && (MEM_TIMEOUT != 0)) begin
      w_wait_cnt_next = r_wait_cnt + CW'(1);
    end else begin
      w_wait_cnt_next = '0;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (i_mem_ready)    w_next_state = S_DECODE;
        else if (w_timeout) w_next_state = S_FAULT;
        else                w_next_state = S_FETCH;
      end
      S_DECODE: begin
        case (w_opcode)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECR;
          OP_ITYPE:          w_next_state = S_EXECI;
          OP_LUI:            w_next_state = S_LUI;
          OP_BRANCH:         w_next_state = branch_legal(w_funct3) ? S_BRANCH : S_FAULT;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALR;
          default:           w_next_state = S_FAULT;
        endcase
      end
      S_MEMADR:  w_next_state = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (i_mem_ready)    w_next_state = S_MEMWB;
        else if (w_timeout) w_next_state = S_FAULT;
        else                w_next_state = S_MEMREAD;
      end
      S_MEMWRITE: begin
        if (i_mem_ready)    w_next_state = S_FETCH;
        else if (w_timeout) w_next_state = S_FAULT;
        else                w_next_state = S_MEMWRITE;
      end
      S_MEMWB:                   w_next_state = S_FETCH;
      S_EXECR, S_EXECI, S_LUI:   w_next_state = S_ALUWB;
      S_ALUWB:                   w_next_state = S_FETCH;
      S_BRANCH:                  w_next_state = S_FETCH;
      S_JAL:                     w_next_state = S_ALUWB;
      S_JALR:                    w_next_state = S_JLINK;
      S_JLINK:                   w_next_state = S_ALUWB;
      S_FAULT:                   w_next_state = S_FAULT;
      default:                   w_next_state = S_FAULT;
    endcase
  end

  // Output decode; everything forced low during reset
  always_comb begin
    o_pc_write   = 1'b0;
    o_ir_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_adr_src    = 1'b0;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_result_src = 2'b00;
    o_imm_src    = 3'b000;
    o_alu_ctrl   = ALU_ADD;
    o_fault      = 1'b0;
    if (i_rst) begin
      o_fault = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          o_mem_read   = 1'b1;
          o_alu_src_b  = 2'b10;
          o_result_src = 2'b10;
          o_ir_write   = i_mem_ready;
          o_pc_write   = i_mem_ready;
        end
        // JAL needs its J-immediate target in ALUOut; everything else precomputes the branch target
        S_DECODE: begin
          o_alu_src_a = 2'b01;
          o_alu_src_b = 2'b01;
          o_imm_src   = (w_opcode == OP_JAL) ? 3'b011 : 3'b010;
        end
        S_MEMADR: begin
          o_alu_src_a = 2'b10;
          o_alu_src_b = 2'b01;
          o_imm_src   = (w_opcode == OP_STORE) ? 3'b001 : 3'b000;
        end
        S_MEMREAD: begin
          o_mem_read = 1'b1;
          o_adr_src  = 1'b1;
        end
        S_MEMWB: begin
          o_reg_write  = 1'b1;
          o_result_src = 2'b01;
        end
        S_MEMWRITE: begin
          o_mem_write = 1'b1;
          o_adr_src   = 1'b1;
        end
        S_EXECR: begin
          o_alu_src_a = 2'b10;
          o_alu_ctrl  = alu_decode(w_funct3, w_funct7_5, 1'b1);
        end
        S_EXECI: begin
          o_alu_src_a = 2'b10;
          o_alu_src_b = 2'b01;
          o_alu_ctrl  = alu_decode(w_funct3, w_funct7_5, 1'b0);
        end
        S_LUI: begin
          o_alu_src_b = 2'b01;
          o_imm_src   = 3'b100;
          o_alu_ctrl  = ALU_PASS_B;
        end
        S_ALUWB: o_reg_write = 1'b1;
        S_BRANCH: begin
          o_alu_src_a = 2'b10;
          o_alu_ctrl  = ALU_SUB;
          o_pc_write  = branch_taken(w_funct3, i_zero, i_lt, i_ltu);
        end
        S_JAL: begin
          o_pc_write  = 1'b1;
          o_alu_src_a = 2'b01;
          o_alu_src_b = 2'b10;
        end
        S_JALR: begin
          o_pc_write   = 1'b1;
          o_alu_src_a  = 2'b10;
          o_alu_src_b  = 2'b01;
          o_result_src = 2'b10;
        end
        S_JLINK: begin
          o_alu_src_a = 2'b01;
          o_alu_src_b = 2'b10;
        end
        S_FAULT: o_fault = 1'b1;
        default: o_fault = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-instruction step-plan reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_multicycle_control;

  localparam int TO_A = 16;
  localparam bit FB_A = 1'b1;
  localparam int TO_B = 4;
  localparam bit FB_B = 1'b0;

  localparam int ST_FETCH = 0, ST_DEC = 1, ST_MADR = 2, ST_MRD = 3, ST_MWB = 4,
                 ST_MWR = 5, ST_EXR = 6, ST_EXI = 7, ST_LUI = 8, ST_WB = 9,
                 ST_BR = 10, ST_JAL = 11, ST_JALR = 12, ST_LINK = 13, ST_FAULT = 14;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_JAL  = 32'h008000EF;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        zero, lt, ltu, mem_ready;

  logic       a_pcw, a_irw, a_rw, a_mr, a_mw, a_adr, a_flt;
  logic [1:0] a_sa, a_sb, a_res;
  logic [2:0] a_imm;
  logic [3:0] a_alu;
  logic       b_pcw, b_irw, b_rw, b_mr, b_mw, b_adr, b_flt;
  logic [1:0] b_sa, b_sb, b_res;
  logic [2:0] b_imm;
  logic [3:0] b_alu;

  wire [19:0] out_a = {a_pcw, a_irw, a_rw, a_mr, a_mw, a_adr, a_sa, a_sb, a_res, a_imm, a_alu, a_flt};
  wire [19:0] out_b = {b_pcw, b_irw, b_rw, b_mr, b_mw, b_adr, b_sa, b_sb, b_res, b_imm, b_alu, b_flt};

  int n_total = 0;
  int n_pass  = 0;
  int cycle   = 0;

  // Reference model: per instance, a plan of steps for the current instruction
  bit m_flt  [2];
  int m_plan [2][4];
  int m_len  [2];
  int m_pos  [2];
  int m_wait [2];

  multicycle_control #(.MEM_TIMEOUT(TO_A), .FULL_BRANCH(FB_A)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_zero(zero), .i_lt(lt), .i_ltu(ltu),
    .i_mem_ready(mem_ready),
    .o_pc_write(a_pcw), .o_ir_write(a_irw), .o_reg_write(a_rw), .o_mem_read(a_mr),
    .o_mem_write(a_mw), .o_adr_src(a_adr), .o_alu_src_a(a_sa), .o_alu_src_b(a_sb),
    .o_result_src(a_res), .o_imm_src(a_imm), .o_alu_ctrl(a_alu), .o_fault(a_flt)
  );

  multicycle_control #(.MEM_TIMEOUT(TO_B), .FULL_BRANCH(FB_B)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_zero(zero), .i_lt(lt), .i_ltu(ltu),
    .i_mem_ready(mem_ready),
    .o_pc_write(b_pcw), .o_ir_write(b_irw), .o_reg_write(b_rw), .o_mem_read(b_mr),
    .o_mem_write(b_mw), .o_adr_src(b_adr), .o_alu_src_a(b_sa), .o_alu_src_b(b_sb),
    .o_result_src(b_res), .o_imm_src(b_imm), .o_alu_ctrl(b_alu), .o_fault(b_flt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cur_step(input int k);
    if (m_flt[k]) return ST_FAULT;
    if (m_pos[k] >= m_len[k]) return ST_FETCH;
    return m_plan[k][m_pos[k]];
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic b30, input bit is_r);
    if (f3 == 3'd0) return (is_r && b30) ? 4'd1 : 4'd0;
    if (f3 == 3'd5) return b30 ? 4'd9 : 4'd8;
    case (f3)
      3'd1:    return 4'd7;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3);
    case (f3)
      3'd0:    return zero;
      3'd1:    return !zero;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return ltu;
      3'd7:    return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [19:0] expect_out(input int st);
    logic pcw, irw, rw, mr, mw, adr, flt;
    logic [1:0] sa, sb, res;
    logic [2:0] imm;
    logic [3:0] alu;
    logic [2:0] f3;
    f3 = instr[14:12];
    {pcw, irw, rw, mr, mw, adr, flt} = 7'd0;
    sa = 2'd0; sb = 2'd0; res = 2'd0; imm = 3'd0; alu = 4'd0;
    case (st)
      ST_FETCH: begin mr = 1'b1; irw = mem_ready; pcw = mem_ready; sb = 2'd2; res = 2'd2; end
      ST_DEC:   begin sa = 2'd1; sb = 2'd1; imm = (instr[6:0] == 7'b1101111) ? 3'd3 : 3'd2; end
      ST_MADR:  begin sa = 2'd2; sb = 2'd1; imm = (instr[6:0] == 7'b0100011) ? 3'd1 : 3'd0; end
      ST_MRD:   begin mr = 1'b1; adr = 1'b1; end
      ST_MWB:   begin rw = 1'b1; res = 2'd1; end
      ST_MWR:   begin mw = 1'b1; adr = 1'b1; end
      ST_EXR:   begin sa = 2'd2; alu = alu_of(f3, instr[30], 1'b1); end
      ST_EXI:   begin sa = 2'd2; sb = 2'd1; alu = alu_of(f3, instr[30], 1'b0); end
      ST_LUI:   begin sb = 2'd1; imm = 3'd4; alu = 4'd10; end
      ST_WB:    begin rw = 1'b1; end
      ST_BR:    begin sa = 2'd2; alu = 4'd1; pcw = taken(f3); end
      ST_JAL:   begin pcw = 1'b1; sa = 2'd1; sb = 2'd2; end
      ST_JALR:  begin pcw = 1'b1; sa = 2'd2; sb = 2'd1; res = 2'd2; end
      ST_LINK:  begin sa = 2'd1; sb = 2'd2; end
      default:  begin flt = 1'b1; end
    endcase
    return {pcw, irw, rw, mr, mw, adr, sa, sb, res, imm, alu, flt};
  endfunction

  task automatic set_plan(input int k, input int n, input int s0, input int s1, input int s2);
    m_plan[k][0] = s0; m_plan[k][1] = s1; m_plan[k][2] = s2;
    m_len[k] = n; m_pos[k] = 0;
  endtask

  task automatic plan_from(input int k, input bit fb);
    logic [2:0] f3;
    f3 = instr[14:12];
    case (instr[6:0])
      7'b0000011: set_plan(k, 3, ST_MADR, ST_MRD, ST_MWB);
      7'b0100011: set_plan(k, 2, ST_MADR, ST_MWR, 0);
      7'b0110011: set_plan(k, 2, ST_EXR, ST_WB, 0);
      7'b0010011: set_plan(k, 2, ST_EXI, ST_WB, 0);
      7'b0110111: set_plan(k, 2, ST_LUI, ST_WB, 0);
      7'b1101111: set_plan(k, 2, ST_JAL, ST_WB, 0);
      7'b1100111: set_plan(k, 3, ST_JALR, ST_LINK, ST_WB);
      7'b1100011: begin
        if (f3 == 3'd0 || f3 == 3'd1 || (fb && f3 >= 3'd4)) set_plan(k, 1, ST_BR, 0, 0);
        else m_flt[k] = 1'b1;
      end
      default: m_flt[k] = 1'b1;
    endcase
  endtask

  task automatic advance(input int k, input int tmo, input bit fb);
    int st;
    st = cur_step(k);
    if (rst) begin
      m_flt[k] = 1'b0; m_len[k] = 0; m_pos[k] = 0; m_wait[k] = 0;
    end else if (m_flt[k]) begin
      m_wait[k] = 0;
    end else if (st == ST_FETCH || st == ST_MRD || st == ST_MWR) begin
      if (mem_ready) begin
        m_wait[k] = 0;
        if (st == ST_FETCH) set_plan(k, 1, ST_DEC, 0, 0);
        else m_pos[k] = m_pos[k] + 1;
      end else if (tmo != 0 && m_wait[k] + 1 >= tmo) begin
        m_flt[k] = 1'b1; m_wait[k] = 0;
      end else begin
        m_wait[k] = m_wait[k] + 1;
      end
    end else if (st == ST_DEC) begin
      plan_from(k, fb);
    end else begin
      m_pos[k] = m_pos[k] + 1;
    end
  endtask

  // Per-cycle comparison of both DUTs against the model, then model advance
  initial begin
    m_flt[0] = 1'b0; m_flt[1] = 1'b0;
    m_len[0] = 0; m_len[1] = 0; m_pos[0] = 0; m_pos[1] = 0; m_wait[0] = 0; m_wait[1] = 0;
    forever begin
      @(negedge clk);
      cycle = cycle + 1;
      for (int k = 0; k < 2; k++) begin
        logic [19:0] exp_v;
        logic [19:0] got_v;
        exp_v = rst ? 20'h0 : expect_out(cur_step(k));
        got_v = (k == 0) ? out_a : out_b;
        n_total = n_total + 1;
        if (got_v === exp_v) n_pass = n_pass + 1;
        else $display("FAIL model_cmp dut%0d cycle %0d step %0d instr %h: got %h want %h",
                      k, cycle, cur_step(k), instr, got_v, exp_v);
      end
      advance(0, TO_A, FB_A);
      advance(1, TO_B, FB_B);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total = n_total + 1;
    if (got === want) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after the first post-reset edge (FETCH cycle)
  task automatic do_reset();
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0:       r[6:0] = 7'b0110011;
      1:       r[6:0] = 7'b0010011;
      2:       r[6:0] = 7'b0000011;
      3:       r[6:0] = 7'b0100011;
      4:       r[6:0] = 7'b0110111;
      5, 6:    r[6:0] = 7'b1100011;
      7:       r[6:0] = 7'b1101111;
      8, 9:    r[6:0] = 7'b1100111;
      default: r[6:0] = r[6:0];
    endcase
    return r;
  endfunction

  initial begin
    int stall;
    rst = 1'b1; instr = 32'h0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;

    @(negedge clk);
    chk("reset_outs_a", {12'h0, out_a}, 32'h0);
    chk("reset_outs_b", {12'h0, out_b}, 32'h0);

    // add x3,x1,x2 with zero-wait memory
    do_reset(); instr = I_ADD; mem_ready = 1'b1;
    @(negedge clk); chk("add_fetch_mr", a_mr, 1); chk("add_fetch_irw", a_irw, 1);
    nxt(); @(negedge clk); chk("add_dec_sa", a_sa, 1); chk("add_dec_rw", a_rw, 0);
    nxt(); @(negedge clk); chk("add_ex_alu", a_alu, 0); chk("add_ex_rw", a_rw, 0); chk("add_ex_sa", a_sa, 2);
    nxt(); @(negedge clk); chk("add_wb_rw", a_rw, 1); chk("add_wb_res", a_res, 0);
    nxt(); @(negedge clk); chk("add_next_fetch", a_mr, 1);

    // lw with three wait cycles in MEMREAD: 8 cycles total
    do_reset(); instr = I_LW; mem_ready = 1'b1;
    @(negedge clk);
    nxt(); @(negedge clk);
    nxt(); @(negedge clk); chk("lw_madr_sa", a_sa, 2); chk("lw_madr_imm", a_imm, 0);
    for (int i = 0; i < 4; i++) begin
      nxt(); mem_ready = (i == 3);
      @(negedge clk); chk("lw_memread_strobes", {a_mr, a_adr}, 2'b11);
    end
    nxt(); @(negedge clk); chk("lw_memwb_rw", a_rw, 1); chk("lw_memwb_res", a_res, 1);
    nxt(); @(negedge clk); chk("lw_next_fetch", {a_mr, a_adr}, 2'b10);

    // blt taken / not taken, and illegal when only BEQ/BNE are decoded
    do_reset(); instr = I_BLT; mem_ready = 1'b1; lt = 1'b1;
    @(negedge clk); nxt(); @(negedge clk);
    nxt(); @(negedge clk); chk("blt_taken_pcw", a_pcw, 1); chk("blt_nofull_fault", b_flt, 1);
    do_reset(); lt = 1'b0;
    @(negedge clk); nxt(); @(negedge clk);
    nxt(); @(negedge clk); chk("blt_not_taken_pcw", a_pcw, 0);

    // Illegal opcode: sticky fault until reset
    do_reset(); instr = I_ILL;
    @(negedge clk); nxt(); @(negedge clk); chk("ill_dec_fault", a_flt, 0);
    nxt(); @(negedge clk); chk("ill_fault", a_flt, 1);
    nxt(); nxt(); @(negedge clk); chk("ill_fault_held", {a_flt, a_mr}, 2'b10);
    nxt(); rst = 1'b1; @(negedge clk); chk("ill_reset_outs", {12'h0, out_a}, 32'h0);
    nxt(); rst = 1'b0; @(negedge clk); chk("ill_after_reset", {a_flt, a_mr}, 2'b01);

    // Fetch timeout: stuck-low ready faults after MEM_TIMEOUT wait cycles
    do_reset(); mem_ready = 1'b0; instr = I_ADD;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 4)  chk("to4_b_no_fault", b_flt, 0);
      if (c == 5)  chk("to4_b_fault", b_flt, 1);
      if (c == 16) chk("to16_last_wait", {a_flt, a_mr}, 2'b01);
      if (c == 17) chk("to16_fault", a_flt, 1);
      nxt();
    end
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      mem_ready = (c == 16);
      @(negedge clk);
      nxt();
    end
    @(negedge clk); chk("to16_ready_wins", {a_flt, a_mr, a_sa}, 4'b0001);

    // jal
    do_reset(); instr = I_JAL; mem_ready = 1'b1;
    @(negedge clk); nxt(); @(negedge clk);
    nxt(); @(negedge clk); chk("jal_pcw", a_pcw, 1); chk("jal_srcs", {a_sa, a_sb, a_alu}, 8'b0110_0000);
    nxt(); @(negedge clk); chk("jal_wb_rw", a_rw, 1);

    // Randomized traffic against the model
    do_reset();
    stall = 0;
    for (int c = 0; c < 4000; c++) begin
      nxt();
      rst = ($urandom_range(0, 299) == 0) || (m_flt[0] && $urandom_range(0, 3) == 0) ||
            (m_flt[1] && $urandom_range(0, 19) == 0);
      {zero, lt, ltu} = 3'($urandom);
      if (stall > 0) begin
        mem_ready = 1'b0;
        stall = stall - 1;
      end else begin
        mem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 49) == 0) stall = $urandom_range(2, 20);
      end
      if (cur_step(0) == ST_FETCH) instr = gen_instr();
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multicycle control unit for the RISC-V core, replacing the single-cycle decoder. A registered state machine sequences fetch, decode, execute, memory and writeback over several cycles. It waits on a memory ready handshake with an optional timeout, and decodes all six conditional branches. Output selects drive the shared-memory multicycle datapath: PC, OldPC, IR, A/B, ALUOut and Data registers.

## Interface
- `MEM_TIMEOUT`, default 16: wait-state cycles without `mem_ready` before entering FAULT. 0 disables the timeout.
- `FULL_BRANCH`, default 1: 1 decodes BEQ/BNE/BLT/BGE/BLTU/BGEU; 0 decodes BEQ/BNE only, and other branch funct3 values are illegal.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 32: IR contents, valid from DECODE onward.
- `zero`, `lt`, `ltu` in 1 each: ALU flags (A==B, signed A<B, unsigned A<B).
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write` out 1 each.
- `adr_src` out 1: memory address source. 0 = PC, 1 = ALUOut.
- `alu_src_a` out 2: 00 = PC, 01 = OldPC, 10 = A.
- `alu_src_b` out 2: 00 = B, 01 = imm, 10 = const 4.
- `result_src` out 2: 00 = ALUOut, 01 = Data, 10 = ALU result.
- `imm_src` out 3: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `alu_ctrl` out 4: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASS_B.
- `fault` out 1: sticky illegal-opcode or timeout flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, LUI, ALUWB, BRANCH, JAL, JALR, FAULT.
- Outputs are Moore-style (decoded from state and `instr`). The only exceptions are `pc_write` in BRANCH and the wait-state strobes, which also depend on the flags and `mem_ready`.
- Unlisted strobes are 0. Unlisted selects are don't-care, but the RTL drives them to 0.
- **FETCH**
  - Drives `mem_read=1`, `adr_src=0`, PC+4 (A=PC, B=4, ADD) with `result_src=10`.
  - Holds while `mem_ready=0`.
  - On `mem_ready=1`: `ir_write=1`, `pc_write=1`, next state DECODE.
- **DECODE**
  - Computes OldPC+imm(B) into ALUOut.
  - Dispatches on opcode: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 0110111 → LUI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; anything else → FAULT.
  - A branch with undecoded funct3 also goes to FAULT.
- **MEMADR**: A+imm (I for loads, S for stores), ADD. Next state is MEMREAD for loads, MEMWRITE for stores.
- **MEMREAD**: `mem_read=1`, `adr_src=1`. Waits for `mem_ready`, then goes to MEMWB.
- **MEMWB**: `reg_write=1`, `result_src=01`. Next state FETCH.
- **MEMWRITE**: `mem_write=1`, `adr_src=1`. Waits for `mem_ready`, then goes to FETCH.
- **EXECR / EXECI**
  - ALU op comes from funct3/funct7[5]: 000 → ADD, or SUB when R-type with funct7[5]=1; 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR; 101 → SRL, or SRA when funct7[5]=1; 110 → OR; 111 → AND.
  - EXECI uses `alu_src_b=01` with I-immediate. Next state ALUWB.
- **LUI**: `imm_src=100`, `alu_src_b=01`, PASS_B. Next state ALUWB.
- **ALUWB**: `reg_write=1`, `result_src=00`. Next state FETCH.
- **BRANCH**
  - A−B (SUB); `result_src=00` selects the target from ALUOut.
  - Taken condition by funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
  - `pc_write` equals the taken condition. Next state FETCH.
- **JAL**: `pc_write=1` with `result_src=00` (target). ALU computes OldPC+4 (a=01, b=10), latched to ALUOut. Next state ALUWB.
- **JALR**: A+imm(I); `pc_write=1` with `result_src=10`. Then goes to JAL-like writeback: ALUOut must hold OldPC+4, so JALR proceeds to a JAL-style OldPC+4 compute. The JALR sequence is JALR → JAL-link (`pc_write=0`) → ALUWB.
- **Timeout**
  - A wait counter, ceil(log2(MEM_TIMEOUT+1)) bits, increments each FETCH/MEMREAD/MEMWRITE cycle with `mem_ready=0`.
  - It clears on `mem_ready` or on leaving the state.
  - When it reaches MEM_TIMEOUT the FSM enters FAULT.
- **FAULT**: `fault=1`, all strobes 0. Held until `rst`.

## Timing
- Reset: state=FETCH and wait counter=0. All strobes are 0 in the reset cycle. `fault`=0.
- Reset takes priority mid-access; any outstanding access is abandoned.
- Cycle counts with zero-wait memory:
  - R, I, LUI, JAL, sw: 4
  - lw: 5
  - branch: 3
  - JALR: 5
- Each memory wait cycle adds one cycle.
- `mem_ready` is sampled only in FETCH, MEMREAD and MEMWRITE; elsewhere it is ignored.
- Simultaneous `mem_ready=1` and counter reaching MEM_TIMEOUT: ready wins.

## Test plan
- **add** x3,x1,x2 (0x002081B3), zero-wait: states FETCH, DECODE, EXECR, ALUWB. `alu_ctrl`=0000 in EXECR; `reg_write`=1 only in ALUWB.
- **lw** (0x0000A183) with `mem_ready` low for 3 cycles in MEMREAD: `mem_read`/`adr_src`=1 held for 4 cycles, then MEMWB with `result_src`=01; 8 cycles total.
- **blt** (0x0020C463): with `lt`=1, `pc_write`=1 in BRANCH; with `lt`=0, `pc_write`=0. With `FULL_BRANCH`=0, same instr → FAULT.
- **Illegal opcode** 0x0000007F → FAULT after DECODE; `fault` stays 1 until `rst`, then FETCH with all outputs 0.
- **Timeout** with MEM_TIMEOUT=16 and `mem_ready` stuck low in FETCH → FAULT after 16 cycles. With `mem_ready` rising on cycle 16 → DECODE, no fault.
- **jal** (0x008000EF): `pc_write`=1 in JAL; ALUWB `reg_write`=1; `alu_ctrl`=0000 with `alu_src_a`=01, `alu_src_b`=10.
